// File: rtl/alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_stage
// Purpose  : Registered ALU result/flag capture stage with a 2-entry skid
//            buffer, NZCV architectural flag register and condition evaluator.
// Revision : 1.0 - initial release
// ============================================================================
module alu_flag_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic         in_carry,
  input  logic         in_overflow,
  input  logic         in_upd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_z,
  output logic         out_n,
  output logic         out_c,
  output logic         out_v,
  output logic [3:0]   flags,
  input  logic [3:0]   cond,
  output logic         cond_true
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] result;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         upd;
  } entry_t;

  state_t state_q;
  entry_t main_q;
  entry_t skid_q;
  logic   in_ready_q;
  logic [3:0] flags_q;

  entry_t w_in_entry;
  logic   w_accept;
  logic   w_pop;

  assign w_in_entry = '{result: in_result,
                        z:      (in_result == '0),
                        n:      in_result[N-1],
                        c:      in_carry,
                        v:      in_overflow,
                        upd:    in_upd};

  assign w_accept = in_valid & in_ready_q;
  assign w_pop    = out_valid & out_ready;

  // in_ready is registered, so it is updated alongside each FULL transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_accept) begin
            main_q  <= w_in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_pop) begin
            skid_q     <= w_in_entry;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (w_pop && !w_accept) begin
            state_q <= EMPTY;
          end else if (w_accept && w_pop) begin
            main_q <= w_in_entry;
          end
        end
        FULL: begin
          if (w_pop) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (w_pop && main_q.upd) begin
      flags_q <= {main_q.n, main_q.z, main_q.c, main_q.v};
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = main_q.result;
  assign out_z      = main_q.z;
  assign out_n      = main_q.n;
  assign out_c      = main_q.c;
  assign out_v      = main_q.v;
  assign flags      = flags_q;

  logic w_fn, w_fz, w_fc, w_fv;
  assign {w_fn, w_fz, w_fc, w_fv} = flags_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = w_fz;
      4'd1:  cond_true = !w_fz;
      4'd2:  cond_true = w_fc;
      4'd3:  cond_true = !w_fc;
      4'd4:  cond_true = w_fn;
      4'd5:  cond_true = !w_fn;
      4'd6:  cond_true = w_fv;
      4'd7:  cond_true = !w_fv;
      4'd8:  cond_true = w_fc & !w_fz;
      4'd9:  cond_true = !w_fc | w_fz;
      4'd10: cond_true = (w_fn == w_fv);
      4'd11: cond_true = (w_fn != w_fv);
      4'd12: cond_true = !w_fz & (w_fn == w_fv);
      4'd13: cond_true = w_fz | (w_fn != w_fv);
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_flag_stage
// Purpose  : Randomized self-checking bench for alu_flag_stage (N=4) against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_result = 4'd0;
  logic       in_carry = 1'b0;
  logic       in_overflow = 1'b0;
  logic       in_upd = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_z, out_n, out_c, out_v;
  logic [3:0] flags;
  logic [3:0] cond = 4'd0;
  logic       cond_true;

  alu_flag_stage #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry),
    .in_overflow(in_overflow), .in_upd(in_upd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_z(out_z), .out_n(out_n),
    .out_c(out_c), .out_v(out_v),
    .flags(flags), .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic       c;
    logic       v;
    logic       upd;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_flags = 4'd0;
  logic       m_ready = 1'b1;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  // Condition truth computed from the flag meanings as signed/unsigned compares.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    logic ge;
    {n, z, cy, v} = f;
    ge = (n == v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return ge;
      4'd11: return !ge;
      4'd12: return ge && !z;
      4'd13: return !(ge && !z);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] r, input logic c,
                       input logic o, input logic u);
    in_valid = v; in_result = r; in_carry = c; in_overflow = o; in_upd = u;
  endtask

  // One clock edge for DUT and model; leaves time 1 unit after the edge.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && m_ready;
    pop = (mq.size() > 0) && out_ready;
    e.r = in_result; e.c = in_carry; e.v = in_overflow; e.upd = in_upd;
    @(posedge clk);
    if (pop) begin
      ent_t h;
      h = mq.pop_front();
      if (h.upd) m_flags = {h.r[3], (h.r == 4'd0), h.c, h.v};
    end
    if (acc) mq.push_back(e);
    m_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_flags = 4'd0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if ({out_result, out_z, out_n, out_c, out_v} !== 8'h00)
      $display("FAIL reset_out: got %h want 00", {out_result, out_z, out_n, out_c, out_v}); else pass_cnt++;
    total_cnt++;
    if (flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++;
    if ({out_z, out_n, out_c, out_v} !== 4'b1010)
      $display("FAIL single_flags_out: got %b want 1010", {out_z, out_n, out_c, out_v}); else pass_cnt++;
    step();
    cond = 4'd0;
    #1;
    total_cnt++;
    if (flags !== 4'b0110 || flags !== m_flags)
      $display("FAIL single_arch_flags: got %b want 0110 (model %b)", flags, m_flags); else pass_cnt++;
    total_cnt++;
    if (cond_true !== 1'b1) $display("FAIL single_eq: got %b want 1", cond_true); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || in_ready !== m_ready)
      $display("FAIL bp_ready_low: got %b want 0", in_ready); else pass_cnt++;
    step();  // in_valid still high while not ready: must be ignored
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (out_result !== 4'b0001 || out_valid !== 1'b1)
      $display("FAIL bp_hold: got %b/%b want 1/0001", out_valid, out_result); else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_result !== 4'b1000 || out_n !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL bp_second: got %b n=%b want 1000 n=1", out_result, out_n); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || mq.size() != 0)
      $display("FAIL bp_empty: got %b want 0 (model %0d left)", out_valid, mq.size()); else pass_cnt++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || out_result !== 4'(i) || out_z !== (i == 0) || out_n !== (i >= 8))
        $display("FAIL stream_%0d: got v=%b r=%0d z=%b n=%b want r=%0d", i, out_valid, out_result,
                 out_z, out_n, i);
      else pass_cnt++;
      total_cnt++;
      if (flags !== m_flags || in_ready !== 1'b1)
        $display("FAIL stream_flags_%0d: got %b rdy=%b want %b rdy=1", i, flags, in_ready, m_flags);
      else pass_cnt++;
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_flag_mask();
    out_ready = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    total_cnt++;
    if (flags !== 4'b1000) $display("FAIL mask_flags: got %b want 1000", flags); else pass_cnt++;
    cond = 4'd10;
    #1;
    total_cnt++;
    if (cond_true !== 1'b0) $display("FAIL mask_ge: got %b want 0", cond_true); else pass_cnt++;
    cond = 4'd11;
    #1;
    total_cnt++;
    if (cond_true !== 1'b1) $display("FAIL mask_lt: got %b want 1", cond_true); else pass_cnt++;
  endtask

  task automatic test_cond();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 4'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        total_cnt++;
        if (cond_true !== ref_cond(m_flags, 4'(c)) || flags !== m_flags)
          $display("FAIL cond_%0d: flags=%b got %b want %b (model flags %b)", c, flags, cond_true,
                   ref_cond(m_flags, 4'(c)), m_flags);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1)), 4'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)));
      out_ready = ($urandom_range(3) != 0);
      cond = 4'($urandom);
      step();
      total_cnt++;
      if (out_valid !== (mq.size() > 0) || in_ready !== m_ready || flags !== m_flags ||
          cond_true !== ref_cond(m_flags, cond) ||
          (mq.size() > 0 && {out_result, out_z, out_n, out_c, out_v} !==
           {mq[0].r, (mq[0].r == 4'd0), mq[0].r[3], mq[0].c, mq[0].v}))
        $display("FAIL random_%0d: got v=%b r=%h rdy=%b f=%b ct=%b want v=%b rdy=%b f=%b", i,
                 out_valid, out_result, in_ready, flags, cond_true, (mq.size() > 0), m_ready,
                 m_flags);
      else pass_cnt++;
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(1'b1, 4'b1001, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (in_ready !== 1'b0 || flags === 4'b0000)
      $display("FAIL areset_pre: got rdy=%b flags=%b want rdy=0 flags!=0", in_ready, flags); else pass_cnt++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_result !== 4'd0 || flags !== 4'd0)
      $display("FAIL areset_now: got v=%b r=%h f=%b want 0/0/0", out_valid, out_result, flags);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL areset_after: got rdy=%b v=%b want 1/0", in_ready, out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_flag_mask();
    test_cond();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
